// File: rtl/knn_sort_pkg.sv
// Shared types and helpers for the streaming top-K bitonic sorter.
// FSM encoding, layer-count functions and the sentinel value.
package knn_sort_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SORT,
        ST_SELECT,
        ST_MERGE,
        ST_DONE
    } state_t;

    function automatic int sort_layers(input int l);
        return l * (l + 1) / 2;
    endfunction

    function automatic int merge_layers(input int l);
        return l;
    endfunction

    // Worst possible key for the direction, so it always loses a select
    function automatic logic [63:0] sentinel(input logic dir, input int w);
        return dir ? ((64'd1 << w) - 64'd1) : 64'd0;
    endfunction

endpackage

// File: rtl/bitonic_cx_layer.sv
// One combinational layer of K/2 compare-exchange cells.
// Sort mode alternates direction per k-block; merge mode uses dir everywhere.
module bitonic_cx_layer
    import knn_sort_pkg::*;
#(
    parameter int L      = 2,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    localparam int K     = 1 << L
) (
    input  logic [L-1:0]                 i_j,
    input  logic [L:0]                   i_k,
    input  logic                         i_dir,
    input  logic                         i_merge,
    input  logic [K-1:0][W-1:0]          i_d,
    input  logic [K-1:0][TYPE_W-1:0]     i_t,
    output logic [K-1:0][W-1:0]          o_d,
    output logic [K-1:0][TYPE_W-1:0]     o_t
);

    logic [L-1:0] w_p;
    logic [L-1:0] w_lo;
    logic [L-1:0] w_hi;
    logic         w_up;
    logic         w_sw;

    always_comb begin
        o_d  = i_d;
        o_t  = i_t;
        w_p  = '0;
        w_lo = '0;
        w_hi = '0;
        w_up = 1'b0;
        w_sw = 1'b0;
        for (int i = 0; i < K; i++) begin
            w_p  = L'(i) ^ i_j;
            w_lo = (L'(i) < w_p) ? L'(i) : w_p;
            w_hi = w_lo ^ i_j;
            w_up = i_merge ? i_dir
                 : ((({1'b0, w_lo} & i_k) == '0) ? i_dir : ~i_dir);
            // Strict disorder only: equal keys stay where they are
            w_sw = w_up ? (i_d[w_lo] > i_d[w_hi])
                        : (i_d[w_lo] < i_d[w_hi]);
            if (w_sw) begin
                o_d[i] = i_d[w_p];
                o_t[i] = i_t[w_p];
            end
        end
    end

endmodule

// File: rtl/knn_topk_stream_sorter.sv
// Streaming top-K selector: folded bitonic sort, select and merge per block.
// Optional per-element masking is enabled with `define KNN_TOPK_MASK_EN.
module knn_topk_stream_sorter
    import knn_sort_pkg::*;
#(
    parameter int L      = 2,
    parameter int W      = 16,
    parameter int TYPE_W = 3,
    localparam int K     = 1 << L
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  in_last,
    input  logic                  ascending,
`ifdef KNN_TOPK_MASK_EN
    input  logic [K-1:0]          in_mask,
`endif
    input  logic [W*K-1:0]        in,
    input  logic [TYPE_W*K-1:0]   in_type,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [W*K-1:0]        out,
    output logic [TYPE_W*K-1:0]   out_type
);

    localparam int SN = sort_layers(L);
    localparam int MN = merge_layers(L);
    localparam int CW = $clog2(SN + 1);
    localparam logic [W-1:0] SENT1 = W'(sentinel(1'b1, W));
    localparam logic [L-1:0] J_TOP = L'(1) << (L - 1);

    state_t r_state;
    state_t w_next;

    logic [K-1:0][W-1:0]      r_wd;
    logic [K-1:0][TYPE_W-1:0] r_wt;
    logic [K-1:0][W-1:0]      r_rd;
    logic [K-1:0][TYPE_W-1:0] r_rt;
    logic                     r_dir;
    logic                     r_first;
    logic                     r_last;
    logic [CW-1:0]            r_cnt;
    logic [L-1:0]             r_j;
    logic [L:0]               r_k;

    logic [K-1:0][W-1:0]      w_in_d;
    logic [K-1:0][TYPE_W-1:0] w_in_t;
    logic [K-1:0][W-1:0]      w_ld_d;
    logic [K-1:0][TYPE_W-1:0] w_ld_t;
    logic                     w_ld_dir;
    logic [W-1:0]             w_ld_sent;

    logic [K-1:0][W-1:0]      w_sel_d;
    logic [K-1:0][TYPE_W-1:0] w_sel_t;
    logic [K-1:0]             w_wb;

    logic                     w_merge;
    logic [K-1:0][W-1:0]      w_lay_in_d;
    logic [K-1:0][TYPE_W-1:0] w_lay_in_t;
    logic [K-1:0][W-1:0]      w_lay_d;
    logic [K-1:0][TYPE_W-1:0] w_lay_t;

    assign w_in_d    = in;
    assign w_in_t    = in_type;
    assign w_ld_dir  = r_first ? ascending : r_dir;
    assign w_ld_sent = W'(sentinel(w_ld_dir, W));

    always_comb begin
        w_ld_d = w_in_d;
        w_ld_t = w_in_t;
`ifdef KNN_TOPK_MASK_EN
        for (int i = 0; i < K; i++) begin
            if (!in_mask[i]) begin
                w_ld_d[i] = w_ld_sent;
                w_ld_t[i] = '0;
            end
        end
`endif
    end

    // Pair best retained with worst work entry; result is bitonic
    always_comb begin
        w_wb    = '0;
        w_sel_d = r_rd;
        w_sel_t = r_rt;
        for (int i = 0; i < K; i++) begin
            w_wb[i] = r_dir ? (r_wd[K-1-i] < r_rd[i])
                            : (r_wd[K-1-i] > r_rd[i]);
            if (w_wb[i]) begin
                w_sel_d[i] = r_wd[K-1-i];
                w_sel_t[i] = r_wt[K-1-i];
            end
        end
    end

    assign w_merge    = (r_state == ST_MERGE);
    assign w_lay_in_d = w_merge ? r_rd : r_wd;
    assign w_lay_in_t = w_merge ? r_rt : r_wt;

    bitonic_cx_layer #(
        .L      (L),
        .W      (W),
        .TYPE_W (TYPE_W)
    ) u_layer (
        .i_j     (r_j),
        .i_k     (r_k),
        .i_dir   (r_dir),
        .i_merge (w_merge),
        .i_d     (w_lay_in_d),
        .i_t     (w_lay_in_t),
        .o_d     (w_lay_d),
        .o_t     (w_lay_t)
    );

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE:   if (in_valid) w_next = ST_SORT;
            ST_SORT:   if (r_cnt == CW'(SN - 1)) w_next = ST_SELECT;
            ST_SELECT: w_next = ST_MERGE;
            ST_MERGE:  if (r_cnt == CW'(MN - 1))
                           w_next = r_last ? ST_DONE : ST_IDLE;
            ST_DONE:   if (out_ready) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_wd    <= '0;
            r_wt    <= '0;
            r_rd    <= {K{SENT1}};
            r_rt    <= '0;
            r_dir   <= 1'b1;
            r_first <= 1'b1;
            r_last  <= 1'b0;
            r_cnt   <= '0;
            r_j     <= L'(1);
            r_k     <= (L+1)'(2);
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_wd   <= w_ld_d;
                        r_wt   <= w_ld_t;
                        r_last <= in_last;
                        r_cnt  <= '0;
                        r_j    <= L'(1);
                        r_k    <= (L+1)'(2);
                        if (r_first) begin
                            r_dir   <= ascending;
                            r_first <= 1'b0;
                            r_rd    <= {K{w_ld_sent}};
                            r_rt    <= '0;
                        end
                    end
                end
                ST_SORT: begin
                    r_wd  <= w_lay_d;
                    r_wt  <= w_lay_t;
                    r_cnt <= r_cnt + CW'(1);
                    if (r_j == L'(1)) begin
                        r_k <= r_k << 1;
                        r_j <= r_k[L-1:0];
                    end else begin
                        r_j <= r_j >> 1;
                    end
                end
                ST_SELECT: begin
                    r_rd  <= w_sel_d;
                    r_rt  <= w_sel_t;
                    r_cnt <= '0;
                    r_j   <= J_TOP;
                end
                ST_MERGE: begin
                    r_rd  <= w_lay_d;
                    r_rt  <= w_lay_t;
                    r_cnt <= r_cnt + CW'(1);
                    r_j   <= r_j >> 1;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_rd    <= {K{SENT1}};
                        r_rt    <= '0;
                        r_first <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign out       = out_valid ? r_rd : '0;
    assign out_type  = out_valid ? r_rt : '0;

endmodule

// File: tb/tb_knn_topk_stream_sorter.sv
// Directed bench for knn_topk_stream_sorter (L=2, W=16, TYPE_W=3).
// Table of frames plus hand sequences for backpressure, reset and masking.
module tb_knn_topk_stream_sorter;

    localparam int L  = 2;
    localparam int W  = 16;
    localparam int TW = 3;
    localparam int K  = 4;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_last = 1'b0;
    logic            ascending = 1'b1;
    logic [K*W-1:0]  din = '0;
    logic [K*TW-1:0] tin = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [K*W-1:0]  dout;
    logic [K*TW-1:0] tout;
`ifdef KNN_TOPK_MASK_EN
    logic [K-1:0]    in_mask = '1;
`endif

    always #5 clk = ~clk;

    knn_topk_stream_sorter #(.L(L), .W(W), .TYPE_W(TW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_last   (in_last),
        .ascending (ascending),
`ifdef KNN_TOPK_MASK_EN
        .in_mask   (in_mask),
`endif
        .in        (din),
        .in_type   (tin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .out_type  (tout)
    );

    typedef struct {
        string       name;
        int          nblk;
        logic [63:0] d0;
        logic [11:0] t0;
        logic        a0;
        logic [63:0] d1;
        logic [11:0] t1;
        logic        a1;
        logic [63:0] ed;
        logic [11:0] et;
    } vec_t;

    vec_t tv[6];
    int   nchk = 0;
    int   nerr = 0;

    function automatic logic [63:0] pd(int a, int b, int c, int e);
        return {16'(e), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [11:0] pt(int a, int b, int c, int e);
        return {3'(e), 3'(c), 3'(b), 3'(a)};
    endfunction

    function automatic vec_t mk(string n, int nb,
                                logic [63:0] d0, logic [11:0] t0, logic a0,
                                logic [63:0] d1, logic [11:0] t1, logic a1,
                                logic [63:0] ed, logic [11:0] et);
        vec_t v;
        v.name = n; v.nblk = nb;
        v.d0 = d0; v.t0 = t0; v.a0 = a0;
        v.d1 = d1; v.t1 = t1; v.a1 = a1;
        v.ed = ed; v.et = et;
        return v;
    endfunction

    task automatic chk(input string n, input logic [63:0] act,
                       input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic send_block(input string n, input logic [63:0] d,
                              input logic [11:0] t, input logic a,
                              input logic last);
        int w;
        w = 0;
        while (!in_ready && w < 60) begin
            @(posedge clk); #1;
            w++;
        end
        if (!in_ready) begin
            nchk++; nerr++;
            $display("FAIL %s/accept_timeout: in_ready stuck low", n);
        end
        din = d; tin = t; ascending = a; in_last = last;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_frame(input vec_t v);
        int c;
        send_block(v.name, v.d0, v.t0, v.a0, v.nblk == 1);
        if (v.nblk == 2) begin
            c = 0;
            while (!in_ready && c < 60) begin
                c++;
                @(posedge clk); #1;
            end
            chk({v.name, "/ready_low"}, 64'(c), 64'd6);
            send_block(v.name, v.d1, v.t1, v.a1, 1'b1);
        end
        c = 0;
        while (!out_valid && c < 60) begin
            @(posedge clk); #1;
            c++;
        end
        chk({v.name, "/latency"}, 64'(c), 64'd6);
        chk({v.name, "/out"}, dout, v.ed);
        chk({v.name, "/type"}, 64'(tout), 64'(v.et));
    endtask

    task automatic consume(input string n);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({n, "/valid_drop"}, 64'(out_valid), 64'd0);
        chk({n, "/ready_back"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        vec_t v;
        tv[0] = mk("single", 1, pd(7,3,9,1), pt(0,1,2,3), 1'b1,
                   '0, '0, 1'b1, pd(1,3,7,9), pt(3,1,0,2));
        tv[1] = mk("two_blk", 2, pd(10,20,30,40), pt(0,1,2,3), 1'b1,
                   pd(5,25,35,1), pt(4,5,6,7), 1'b1,
                   pd(1,5,10,20), pt(7,4,0,1));
        tv[2] = mk("ties", 2, pd(4,4,4,4), pt(1,1,1,1), 1'b1,
                   pd(4,4,4,4), pt(2,2,2,2), 1'b1,
                   pd(4,4,4,4), pt(1,1,1,1));
        tv[3] = mk("desc", 2, pd(7,3,9,1), pt(0,1,2,3), 1'b0,
                   pd(2,8,6,5), pt(4,5,6,7), 1'b1,
                   pd(9,8,7,6), pt(2,5,0,6));
        tv[4] = mk("unsigned_edge", 1,
                   pd(16'hFFFF,0,16'h8000,16'h7FFF), pt(1,2,3,4), 1'b1,
                   '0, '0, 1'b1,
                   pd(0,16'h7FFF,16'h8000,16'hFFFF), pt(2,4,3,0));
        tv[5] = mk("desc_sentinel", 1, pd(0,5,0,3), pt(1,2,3,4), 1'b0,
                   '0, '0, 1'b0, pd(5,3,0,0), pt(2,4,0,0));

        #1;
        chk("reset/in_ready", 64'(in_ready), 64'd1);
        chk("reset/out_valid", 64'(out_valid), 64'd0);
        chk("reset/out", dout, 64'd0);
        chk("reset/out_type", 64'(tout), 64'd0);
        #20 rst = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 6; i++) begin
            run_frame(tv[i]);
            consume(tv[i].name);
        end

        run_frame(tv[1]);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp/out", dout, tv[1].ed);
            chk("bp/valid", 64'(out_valid), 64'd1);
            chk("bp/in_ready", 64'(in_ready), 64'd0);
        end
        consume("bp");
        v = mk("fresh", 1, pd(2,2,2,2), pt(3,3,3,3), 1'b0,
               '0, '0, 1'b0, pd(2,2,2,2), pt(3,3,3,3));
        run_frame(v);
        consume("fresh");

        send_block("rst_mid", pd(0,0,0,0), pt(5,5,5,5), 1'b1, 1'b0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("rst_mid/out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid/in_ready", 64'(in_ready), 64'd1);
        chk("rst_mid/out", dout, 64'd0);
        #3 rst = 1'b1;
        @(negedge clk);
        run_frame(tv[0]);
        consume("after_rst");

`ifdef KNN_TOPK_MASK_EN
        in_mask = 4'b0101;
        v = mk("mask", 1, pd(1,2,3,4), pt(1,2,3,4), 1'b1,
               '0, '0, 1'b1, pd(1,3,16'hFFFF,16'hFFFF), pt(1,3,0,0));
        run_frame(v);
        in_mask = '1;
        consume("mask");
`endif

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
